load_align_unit: RTL and testbench

Parametrised load-data alignment and extension unit between the MEM stage and the data-memory read port. It accepts one load request at a time, issues one or two bus-aligned reads, and merges the returned beats. It then selects the addressed bytes, sign- or zero-extends them to DATA_W, and returns the result on a valid/ready output. Misaligned loads are either split across two bus beats or trapped as address errors, depending on build configuration.

---
 rtl/load_align_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_align_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Load alignment/extension between MEM stage and data-memory read port.
// Define LOAD_MISALIGN_EN to split beat-crossing loads instead of trapping.
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_op,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam bit W64   = (DATA_W == 64);

`ifdef LOAD_MISALIGN_EN
  typedef enum logic [2:0] {
    IDLE, RD0, WAIT0, RD1, WAIT1, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RD0, WAIT0, DONE
  } state_t;
`endif

  state_t            state;
  logic [3:0]        sz, sz_q;
  logic              sgn, sgn_q;
  logic [OFFW-1:0]   off, off_q;
  logic              err;
  logic [DATA_W-1:0] lo, hi, m, res;
`ifdef LOAD_MISALIGN_EN
  logic              cross, cross_q;
  logic [DATA_W-1:0] beat0_q;
`endif

  always_comb begin
    sz  = 4'd4;
    sgn = 1'b1;
    unique case (1'b1)
      req_op == 3'b001: begin sz = 4'd1; sgn = 1'b0; end
      req_op == 3'b010: sz = 4'd1;
      req_op == 3'b011: begin sz = 4'd2; sgn = 1'b0; end
      req_op == 3'b100: sz = 4'd2;
      req_op == 3'b101 && W64: sgn = 1'b0;
      req_op == 3'b110 && W64: sz = 4'd8;
      default: ;
    endcase
  end

  assign off = req_addr[OFFW-1:0];

`ifdef LOAD_MISALIGN_EN
  assign err   = 1'b0;
  assign cross = (int'(off) + int'(sz)) > BYTES;
`else
  // sz-1 wraps to 7 for 8-byte loads, giving the right alignment mask
  assign err = |(req_addr[2:0] & (sz[2:0] - 3'd1));
`endif

  always_comb begin
    lo = mem_rsp_data;
    hi = '0;
`ifdef LOAD_MISALIGN_EN
    if (state == WAIT1) begin
      lo = beat0_q;
      hi = mem_rsp_data;
    end
`endif
  end

  assign m = DATA_W'({hi, lo} >> {off_q, 3'b000});

  always_comb begin
    int   nbits;
    logic sbit;
    nbits = 8 * int'(sz_q);
    sbit  = 1'b0;
    res   = '0;
    for (int i = 0; i < DATA_W; i++)
      if (i == nbits - 1) sbit = m[i];
    for (int i = 0; i < DATA_W; i++)
      res[i] = (i < nbits) ? m[i] : (sgn_q & sbit);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      mem_rd_valid <= 1'b0;
      mem_rd_addr  <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_tag      <= '0;
      out_err      <= 1'b0;
      sz_q         <= 4'd4;
      sgn_q        <= 1'b0;
      off_q        <= '0;
`ifdef LOAD_MISALIGN_EN
      cross_q      <= 1'b0;
      beat0_q      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          sz_q      <= sz;
          sgn_q     <= sgn;
          off_q     <= off;
          out_tag   <= req_tag;
`ifdef LOAD_MISALIGN_EN
          cross_q   <= cross;
`endif
          if (err) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            out_data  <= '0;
          end else begin
            state        <= RD0;
            mem_rd_valid <= 1'b1;
            mem_rd_addr  <= {req_addr[ADDR_W-1:OFFW], OFFW'(0)};
          end
        end
        RD0: if (mem_rd_ready) begin
          mem_rd_valid <= 1'b0;
          state        <= WAIT0;
        end
        WAIT0: if (mem_rsp_valid) begin
`ifdef LOAD_MISALIGN_EN
          if (cross_q) begin
            beat0_q      <= mem_rsp_data;
            state        <= RD1;
            mem_rd_valid <= 1'b1;
            mem_rd_addr  <= mem_rd_addr + ADDR_W'(BYTES);
          end else begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= res;
            out_err   <= 1'b0;
          end
`else
          state     <= DONE;
          out_valid <= 1'b1;
          out_data  <= res;
          out_err   <= 1'b0;
`endif
        end
`ifdef LOAD_MISALIGN_EN
        RD1: if (mem_rd_ready) begin
          mem_rd_valid <= 1'b0;
          state        <= WAIT1;
        end
        WAIT1: if (mem_rsp_valid) begin
          state     <= DONE;
          out_valid <= 1'b1;
          out_data  <= res;
          out_err   <= 1'b0;
        end
`endif
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit (32-bit and 64-bit instances).
// Expectations follow the LOAD_MISALIGN_EN setting of the build.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_op;
  logic [4:0]  req_tag;
  logic        mem_rd_valid, mem_rd_ready;
  logic [31:0] mem_rd_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;

  logic        r64_valid, r64_ready;
  logic [31:0] r64_addr;
  logic [2:0]  r64_op;
  logic [4:0]  r64_tag;
  logic        m64_rd_valid;
  logic [31:0] m64_rd_addr;
  logic        m64_rsp_valid;
  logic [63:0] m64_rsp_data;
  logic        o64_valid, o64_ready;
  logic [63:0] o64_data;
  logic [4:0]  o64_tag;
  logic        o64_err;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int rdv_cnt = 0;
  logic        auto_rsp = 1'b1;
  logic        arsp_valid = 1'b0;
  logic [31:0] arsp_data = '0;
  logic        mrsp_valid = 1'b0;
  logic [31:0] mrsp_data = '0;
  logic [31:0] m0, m1;
  logic [63:0] b64;

  always #5 clk = ~clk;

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_op(req_op), .req_tag(req_tag),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
    .mem_rd_addr(mem_rd_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_err(out_err)
  );

  load_align_unit #(.DATA_W(64), .ADDR_W(32), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(r64_valid), .req_ready(r64_ready),
    .req_addr(r64_addr), .req_op(r64_op), .req_tag(r64_tag),
    .mem_rd_valid(m64_rd_valid), .mem_rd_ready(1'b1),
    .mem_rd_addr(m64_rd_addr),
    .mem_rsp_valid(m64_rsp_valid), .mem_rsp_data(m64_rsp_data),
    .out_valid(o64_valid), .out_ready(o64_ready),
    .out_data(o64_data), .out_tag(o64_tag), .out_err(o64_err)
  );

  assign mem_rsp_valid = arsp_valid | mrsp_valid;
  assign mem_rsp_data  = mrsp_valid ? mrsp_data : arsp_data;

  always @(posedge clk) begin
    arsp_valid <= 1'b0;
    if (mem_rd_valid) rdv_cnt <= rdv_cnt + 1;
    if (mem_rd_valid && mem_rd_ready) begin
      rd_cnt <= rd_cnt + 1;
      if (auto_rsp) begin
        arsp_valid <= 1'b1;
        arsp_data  <= (mem_rd_addr == 32'h1000) ? m0 :
                      (mem_rd_addr == 32'h1004) ? m1 : 32'hDEADBEEF;
      end
    end
  end

  always @(posedge clk) begin
    m64_rsp_valid <= m64_rd_valid;
    m64_rsp_data  <= (m64_rd_addr == 32'h2000) ? b64 : 64'hDEAD;
  end

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic load32(input logic [31:0] a, input logic [2:0] op,
                        input logic [4:0] tg, output int cyc,
                        output logic [31:0] d, output logic [4:0] t,
                        output logic e, output int nrd, output int nrv);
    int r0, v0;
    r0 = rd_cnt;
    v0 = rdv_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_op = op; req_tag = tg;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    d = out_data; t = out_tag; e = out_err;
    nrd = rd_cnt - r0;
    nrv = rdv_cnt - v0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic load64(input logic [31:0] a, input logic [2:0] op,
                        output logic [63:0] d, output logic e);
    int cyc;
    @(negedge clk);
    r64_valid = 1'b1; r64_addr = a; r64_op = op; r64_tag = 5'd7;
    @(negedge clk);
    r64_valid = 1'b0;
    cyc = 1;
    while (!o64_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("cyc64", 64'(cyc), 64'd3);
    d = o64_data; e = o64_err;
    o64_ready = 1'b1;
    @(negedge clk);
    o64_ready = 1'b0;
  endtask

  initial begin
    int cyc, nrd, nrv;
    logic [31:0] d;
    logic [4:0]  t;
    logic        e;
    logic [63:0] d64;
    reset = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_op = '0; req_tag = '0;
    mem_rd_ready = 1'b1; out_ready = 1'b0;
    r64_valid = 1'b0; r64_addr = '0; r64_op = '0; r64_tag = '0;
    o64_ready = 1'b0;
    m0 = '0; m1 = '0; b64 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rd_valid", 64'(mem_rd_valid), 64'd0);
    chk("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);

    m0 = 32'h80FF1234;
    load32(32'h1003, 3'b010, 5'd3, cyc, d, t, e, nrd, nrv);
    chk("lb_data", 64'(d), 64'hFFFFFF80);
    chk("lb_err", 64'(e), 64'd0);
    chk("lb_tag", 64'(t), 64'd3);
    chk("lb_cyc", 64'(cyc), 64'd3);
    chk("lb_reads", 64'(nrd), 64'd1);
    load32(32'h1003, 3'b001, 5'd4, cyc, d, t, e, nrd, nrv);
    chk("lbu_data", 64'(d), 64'h00000080);

    m0 = 32'hBEEF0000;
    load32(32'h1002, 3'b011, 5'd5, cyc, d, t, e, nrd, nrv);
    chk("lhu_data", 64'(d), 64'h0000BEEF);
    load32(32'h1002, 3'b100, 5'd6, cyc, d, t, e, nrd, nrv);
    chk("lh_data", 64'(d), 64'hFFFFBEEF);

    m0 = 32'h80000001;
    load32(32'h1000, 3'b111, 5'd8, cyc, d, t, e, nrd, nrv);
    chk("rsvd_word", 64'(d), 64'h80000001);
    load32(32'h1000, 3'b101, 5'd9, cyc, d, t, e, nrd, nrv);
    chk("lwu32_word", 64'(d), 64'h80000001);

    m0 = 32'h44332211;
    m1 = 32'h88776655;
`ifdef LOAD_MISALIGN_EN
    load32(32'h1001, 3'b000, 5'd10, cyc, d, t, e, nrd, nrv);
    chk("split_data", 64'(d), 64'h55443322);
    chk("split_reads", 64'(nrd), 64'd2);
    chk("split_cyc", 64'(cyc), 64'd5);
    chk("split_err", 64'(e), 64'd0);
    load32(32'h1001, 3'b100, 5'd11, cyc, d, t, e, nrd, nrv);
    chk("mis_in_beat", 64'(d), 64'h00003322);
    chk("mis_in_cyc", 64'(cyc), 64'd3);
    load32(32'h1003, 3'b100, 5'd12, cyc, d, t, e, nrd, nrv);
    chk("lh_split", 64'(d), 64'h00005544);
`else
    load32(32'h1001, 3'b100, 5'd10, cyc, d, t, e, nrd, nrv);
    chk("trap_err", 64'(e), 64'd1);
    chk("trap_data", 64'(d), 64'd0);
    chk("trap_tag", 64'(t), 64'd10);
    chk("trap_cyc", 64'(cyc), 64'd1);
    chk("trap_rdv", 64'(nrv), 64'd0);
    load32(32'h1002, 3'b000, 5'd11, cyc, d, t, e, nrd, nrv);
    chk("trap_word", 64'(e), 64'd1);
    load32(32'h1001, 3'b001, 5'd12, cyc, d, t, e, nrd, nrv);
    chk("lbu_odd_ok", 64'(d), 64'h00000022);
`endif

    // read-side backpressure, then output-side backpressure
    m0 = 32'h80FF1234;
    mem_rd_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h1000; req_op = 3'b001; req_tag = 5'd9;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rd_valid", 64'(mem_rd_valid), 64'd1);
      chk("bp_rd_addr", 64'(mem_rd_addr), 64'h1000);
      @(negedge clk);
    end
    mem_rd_ready = 1'b1;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_out_data", 64'(out_data), 64'h34);
      chk("bp_out_tag", 64'(out_tag), 64'd9);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release", 64'(out_valid), 64'd0);
    chk("bp_idle", 64'(req_ready), 64'd1);

    // reset in WAIT0, then a stale response
    auto_rsp = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h1000; req_op = 3'b000; req_tag = 5'd2;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_rd", 64'(mem_rd_valid), 64'd0);
    mrsp_valid = 1'b1; mrsp_data = 32'h11111111;
    @(negedge clk);
    mrsp_valid = 1'b0;
    @(negedge clk);
    chk("stale_valid", 64'(out_valid), 64'd0);
    chk("stale_ready", 64'(req_ready), 64'd1);
    auto_rsp = 1'b1;
    load32(32'h1003, 3'b010, 5'd1, cyc, d, t, e, nrd, nrv);
    chk("post_rst_lb", 64'(d), 64'hFFFFFF80);

    b64 = 64'h89ABCDEF_00000000;
    load64(32'h2004, 3'b101, d64, e);
    chk("lwu64", d64, 64'h00000000_89ABCDEF);
    load64(32'h2004, 3'b000, d64, e);
    chk("lw64", d64, 64'hFFFFFFFF_89ABCDEF);
    load64(32'h2000, 3'b110, d64, e);
    chk("ld64", d64, 64'h89ABCDEF_00000000);
    chk("ld64_err", 64'(e), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
